instr_encoder: RTL and testbench

- Sequential ARM-subset instruction encoder: the inverse of the control decode stage.
- Accepts structured instruction fields over a valid/ready handshake and assembles the 32-bit machine word.
- Writes consecutive words into instruction memory through a write port with an auto-incrementing address.
- Used as the program loader feeding imem before the pipeline is released from reset.

---
 rtl/instr_encoder.sv | 192 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ARM-subset instruction encoder used as the imem program loader.
// Accepts instruction fields over valid/ready and writes encoded words to consecutive addresses.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Fields of one instruction, grouped so the encoder takes a single argument.
  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        imm_sel;
    logic        link;
    logic [3:0]  cond;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [23:0] imm;
  } fields_t;

  // Builds the machine word and flags words the decoder could not execute.
  function automatic enc_t encode(input fields_t f);
    enc_t        e;
    logic [11:0] src2;
    logic        cmp_class;
    logic        s_eff;
    logic [3:0]  rd_eff;

    e         = '0;
    src2      = f.imm_sel ? f.imm[11:0] : {8'h00, f.rm};
    // TST/TEQ/CMP/CMN only exist to set flags and never write a register.
    cmp_class = (f.cmd[3:2] == 2'b10);
    s_eff     = cmp_class ? 1'b1 : f.s_bit;
    rd_eff    = cmp_class ? 4'h0 : f.rd;

    case (op_e'(f.op))
      OP_DP: begin
        case (f.cmd)
          4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1100,
          4'b1000, 4'b1001, 4'b1010, 4'b1011: e.legal = 1'b1;
          default:                            e.legal = 1'b0;
        endcase
        e.word = {f.cond, 2'b00, f.imm_sel, f.cmd, s_eff, f.rn, rd_eff, src2};
      end
      OP_MEM: begin
        e.legal = 1'b1;
        // Pre-indexed, add offset, word access, no writeback.
        e.word  = {f.cond, 2'b01, ~f.imm_sel, 1'b1, 1'b1, 1'b0, 1'b0, f.link,
                   f.rn, f.rd, src2};
      end
      OP_BR: begin
        e.legal = 1'b1;
        e.word  = {f.cond, 3'b101, f.link, f.imm};
      end
      default: begin
        e.legal = 1'b0;
        e.word  = '0;
      end
    endcase
    return e;
  endfunction

endpackage

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [3:0]        cmd,
  input  logic              s_bit,
  input  logic              imm_sel,
  input  logic              link,
  input  logic [3:0]        cond,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [23:0]       imm,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_illegal
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q;
  logic            err_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;

  fields_t fields;
  enc_t    enc;
  logic    fire;
  logic    enter_load;
  logic    write;

  assign fields = '{op: op, cmd: cmd, s_bit: s_bit, imm_sel: imm_sel, link: link,
                    cond: cond, rn: rn, rd: rd, rm: rm, imm: imm};
  assign enc    = encode(fields);

  // Ready depends on state alone so the producer can never form a loop through in_valid.
  assign in_ready   = (state_q == ST_LOAD) && (count_q != FULL);
  assign fire       = in_valid && in_ready;
  assign write      = fire && enc.legal;
  assign enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_LOAD;
      ST_LOAD: if (finish) state_d = ST_DONE;
      ST_DONE: if (start)  state_d = ST_LOAD;
      default:             state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_load) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (write)              count_q <= count_q + ONE;
      if (fire && !enc.legal) err_q   <= 1'b1;
    end
  end

  // Write port: one-cycle registered stage; address and data hold between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= write;
      if (write) begin
        addr_q  <= {{(29 - ADDR_W){1'b0}}, count_q, 2'b00};
        wdata_q <= enc.word;
      end
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign count       = count_q;
  assign done        = (state_q == ST_DONE);
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed plan scenarios followed by randomized traffic,
// all compared against a field-arithmetic reference model.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, finish, in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [3:0]        cmd;
  logic              s_bit, imm_sel, link;
  logic [3:0]        cond, rn, rd, rm;
  logic [23:0]       imm;
  logic              mem_we;
  logic [31:0]       mem_addr, mem_wdata;
  logic [ADDR_W:0]   count;
  logic              done, err_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_state;
  int          m_count;
  bit          m_err;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .cmd        (cmd),
    .s_bit      (s_bit),
    .imm_sel    (imm_sel),
    .link       (link),
    .cond       (cond),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .imm        (imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .count      (count),
    .done       (done),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference encoding built from field weights (powers of two), not bit concatenation.
  function automatic void ref_encode(output bit legal, output logic [31:0] word);
    longint w;
    longint src;
    bit     cmp_class;
    src = imm_sel ? longint'(imm % 4096) : longint'(rm);
    w   = longint'(cond) * (2 ** 28);
    legal = 1'b1;
    case (op)
      2'd0: begin
        legal     = cmd inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd8, 4'd9, 4'd10, 4'd11};
        cmp_class = (cmd >= 8) && (cmd <= 11);
        w += longint'(imm_sel) * (2 ** 25) + longint'(cmd) * (2 ** 21);
        w += (cmp_class ? 1 : longint'(s_bit)) * (2 ** 20);
        w += longint'(rn) * (2 ** 16) + (cmp_class ? 0 : longint'(rd)) * (2 ** 12) + src;
      end
      2'd1: begin
        w += (2 ** 26) + longint'(1 - imm_sel) * (2 ** 25) + (2 ** 24) + (2 ** 23);
        w += longint'(link) * (2 ** 20) + longint'(rn) * (2 ** 16) + longint'(rd) * (2 ** 12) + src;
      end
      2'd2: w += 5 * (2 ** 25) + longint'(link) * (2 ** 24) + longint'(imm);
      default: legal = 1'b0;
    endcase
    word = w[31:0];
  endfunction

  task automatic check_outputs(input string ph);
    check({ph, ":in_ready"},    32'(in_ready),    32'((m_state == M_LOAD) && (m_count != DEPTH)));
    check({ph, ":mem_we"},      32'(mem_we),      32'(m_we));
    check({ph, ":mem_addr"},    mem_addr,         m_addr);
    check({ph, ":mem_wdata"},   mem_wdata,        m_data);
    check({ph, ":count"},       32'(count),       32'(m_count));
    check({ph, ":done"},        32'(done),        32'(m_state == M_DONE));
    check({ph, ":err_illegal"}, 32'(err_illegal), 32'(m_err));
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_count = 0;
    m_err   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  // Predict the effect of one rising edge, advance to just past it, then compare.
  task automatic step(input string ph);
    bit          rdy, fire, lg;
    logic [31:0] w;
    rdy  = (m_state == M_LOAD) && (m_count != DEPTH);
    ref_encode(lg, w);
    fire = in_valid && rdy;
    m_we = fire && lg;
    if (m_we) begin
      m_addr = 32'(m_count * 4);
      m_data = w;
      m_count++;
    end
    if (fire && !lg) m_err = 1'b1;
    if (m_state == M_LOAD) begin
      if (finish) m_state = M_DONE;
    end else if (start) begin
      m_state = M_LOAD;
      m_count = 0;
      m_err   = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(ph);
  endtask

  task automatic drive(input logic [1:0] o, input logic [3:0] c, input logic s, input logic i,
                       input logic l, input logic [3:0] cn, input logic [3:0] n,
                       input logic [3:0] d, input logic [3:0] m, input logic [23:0] im);
    op = o; cmd = c; s_bit = s; imm_sel = i; link = l;
    cond = cn; rn = n; rd = d; rm = m; imm = im;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step("start");
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    step("finish");
    finish = 1'b0;
  endtask

  task automatic rand_fields();
    logic [3:0] legal_cmds [9];
    int r;
    legal_cmds = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd8, 4'd9, 4'd10, 4'd11};
    r = int'($urandom_range(0, 7));
    op      = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
    cmd     = ($urandom_range(0, 4) != 0) ? legal_cmds[$urandom_range(0, 8)] : 4'($urandom);
    s_bit   = 1'($urandom);
    imm_sel = 1'($urandom);
    link    = 1'($urandom);
    cond    = 4'($urandom);
    rn      = 4'($urandom);
    rd      = 4'($urandom);
    rm      = 4'($urandom);
    imm     = 24'($urandom);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    drive(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 24'd0);
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    step("idle");
    step("idle");

    // 1: ADD R1,R2,#5
    pulse_start();
    drive(2'd0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'hE, 4'd2, 4'd1, 4'd0, 24'h000005);
    in_valid = 1'b1;
    step("t1");
    check("t1_we", 32'(mem_we), 32'd1);
    check("t1_addr", mem_addr, 32'h0);
    check("t1_data", mem_wdata, 32'hE2821005);
    check("t1_count", 32'(count), 32'd1);

    // 2: CMP R3,#0 with s_bit=0 and rd=7
    drive(2'd0, 4'b1010, 1'b0, 1'b1, 1'b0, 4'hE, 4'd3, 4'd7, 4'd0, 24'h000000);
    step("t2");
    check("t2_data", mem_wdata, 32'hE3530000);
    in_valid = 1'b0;
    pulse_finish();

    // 3: LDR then STR back to back
    pulse_start();
    drive(2'd1, 4'd0, 1'b0, 1'b1, 1'b1, 4'hE, 4'd0, 4'd4, 4'd0, 24'h000008);
    in_valid = 1'b1;
    step("t3a");
    check("t3_ldr_data", mem_wdata, 32'hE5904008);
    check("t3_ldr_addr", mem_addr, 32'h0);
    drive(2'd1, 4'd0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd1, 4'd5, 4'd2, 24'h000000);
    step("t3b");
    check("t3_str_we", 32'(mem_we), 32'd1);
    check("t3_str_data", mem_wdata, 32'hE7815002);
    check("t3_str_addr", mem_addr, 32'h4);
    in_valid = 1'b0;
    pulse_finish();

    // 4: BEQ, then an illegal DP cmd, then a legal word at the unchanged address
    pulse_start();
    drive(2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE);
    in_valid = 1'b1;
    step("t4a");
    check("t4_br_data", mem_wdata, 32'h0AFFFFFE);
    drive(2'd0, 4'b0011, 1'b0, 1'b0, 1'b0, 4'hE, 4'd1, 4'd1, 4'd1, 24'h0);
    step("t4b");
    check("t4_ill_we", 32'(mem_we), 32'd0);
    check("t4_ill_err", 32'(err_illegal), 32'd1);
    check("t4_ill_count", 32'(count), 32'd1);
    drive(2'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'hE, 4'd1, 4'd2, 4'd3, 24'h0);
    step("t4c");
    check("t4_next_addr", mem_addr, 32'h4);
    in_valid = 1'b0;
    pulse_finish();

    // 5: fill to DEPTH with valid held high, then finish and restart
    pulse_start();
    drive(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 24'h0);
    in_valid = 1'b1;
    step("t5_ill");
    drive(2'd0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'hE, 4'd2, 4'd1, 4'd0, 24'h000005);
    for (int k = 0; k < 6; k++) begin
      step("t5_fill");
      if (k < 4) check("t5_addr", mem_addr, 32'(k * 4));
    end
    check("t5_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    pulse_finish();
    check("t5_done", 32'(done), 32'd1);
    pulse_start();
    check("t5_count_clr", 32'(count), 32'd0);
    check("t5_err_clr", 32'(err_illegal), 32'd0);

    // start+finish together in LOAD: finish wins; start in LOAD is ignored
    start = 1'b1; finish = 1'b1;
    step("sf_both");
    finish = 1'b0;
    step("sf_restart");
    in_valid = 1'b1;
    step("start_in_load");
    start = 1'b0;
    step("load_more");

    // 6: reset on the cycle after a handshake
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_reset");
    check("t6_we", 32'(mem_we), 32'd0);
    #1;
    reset = 1'b1;
    step("t6_after");
    step("t6_after");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      in_valid = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 19) == 0);
      finish   = ($urandom_range(0, 24) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
